// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencer for the simple RISC datapath.
// Fetches into IR, bumps the PC, and steps each instruction through its
// register-read, execute, write-back and memory phases. All control outputs
// are registered: each one is computed from the state being entered.
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  output logic [2:0] nselA,
  output logic [2:0] nselB,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       pc_sel,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halt
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETAB, S_GETB, S_EXEC, S_WB,
    S_GETA, S_ADDR, S_LDA, S_MRD1, S_MRD2, S_GETD, S_PASS, S_MWR, S_BR, S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] nsela;
    logic [2:0] nselb;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_sel;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halt;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;

  // Branch condition: flags come from the status register, which a preceding
  // CMP has already updated in its EXEC cycle.
  function automatic logic br_taken(input logic [2:0] cd, input logic fn,
                                    input logic fv, input logic fz);
    logic t;
    case (cd)
      3'b000:  t = 1'b1;
      3'b001:  t = fz;
      3'b010:  t = ~fz;
      3'b011:  t = fn ^ fv;
      3'b100:  t = (fn ^ fv) | fz;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic state_t next_of(input state_t s, input logic [2:0] opc,
                                     input logic [1:0] o);
    state_t n;
    case (s)
      S_RST:   n = S_IF1;
      S_IF1:   n = S_IF2;
      S_IF2:   n = S_UPC;
      S_UPC:   n = S_DEC;
      S_DEC: begin
        if (opc == 3'b110 && o == 2'b10)                          n = S_WIMM;
        else if (opc == 3'b110 && o == 2'b00)                     n = S_GETB;
        else if (opc == 3'b101)                                   n = S_GETAB;
        else if ((opc == 3'b011 || opc == 3'b100) && o == 2'b00)  n = S_GETA;
        else if (opc == 3'b001)                                   n = S_BR;
        else                                                      n = S_HALT;
      end
      S_WIMM:  n = S_IF1;
      S_GETAB: n = S_EXEC;
      S_GETB:  n = S_EXEC;
      S_EXEC:  n = (opc == 3'b101 && o == 2'b01) ? S_IF1 : S_WB;
      S_WB:    n = S_IF1;
      S_GETA:  n = S_ADDR;
      S_ADDR:  n = S_LDA;
      S_LDA:   n = (opc == 3'b011) ? S_MRD1 : S_GETD;
      S_MRD1:  n = S_MRD2;
      S_MRD2:  n = S_IF1;
      S_GETD:  n = S_PASS;
      S_PASS:  n = S_MWR;
      S_MWR:   n = S_IF1;
      S_BR:    n = S_IF1;
      S_HALT:  n = S_HALT;
      default: n = S_RST;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [2:0] opc,
                                   input logic [1:0] o, input logic [2:0] cd,
                                   input logic fn, input logic fv, input logic fz);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
      S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
      S_UPC:   c.load_pc = 1'b1;
      S_WIMM:  begin c.nsela = 3'b001; c.vsel = 2'b10; c.write = 1'b1; end
      S_GETAB: begin
        c.nsela = 3'b001; c.nselb = 3'b100; c.loada = 1'b1; c.loadb = 1'b1;
      end
      S_GETB:  begin c.nselb = 3'b100; c.loadb = 1'b1; end
      S_EXEC:  begin
        c.loadc = 1'b1;
        c.asel  = (opc == 3'b110);
        c.loads = (opc == 3'b101 && o == 2'b01);
      end
      S_WB:    begin c.nsela = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
      S_GETA:  begin c.nsela = 3'b001; c.loada = 1'b1; end
      S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LDA:   c.load_addr = 1'b1;
      S_MRD1:  c.mem_cmd = MREAD;
      S_MRD2:  begin
        c.mem_cmd = MREAD; c.nsela = 3'b010; c.vsel = 2'b11; c.write = 1'b1;
      end
      S_GETD:  begin c.nselb = 3'b010; c.loadb = 1'b1; end
      S_PASS:  begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MWR:   c.mem_cmd = MWRITE;
      S_BR:    begin
        c.load_pc = br_taken(cd, fn, fv, fz);
        c.pc_sel  = c.load_pc;
      end
      S_HALT:  c.halt = 1'b1;
      default: c.mem_cmd = MNONE;
    endcase
    return c;
  endfunction

  // Next-state selection from the current state and decoded instruction fields.
  always_comb begin
    nxt = next_of(state, opcode, op);
  end

  // State and registered control outputs; reset forces RST at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_RST;
      ctrl          <= '0;
      ctrl.reset_pc <= 1'b1;
      ctrl.load_pc  <= 1'b1;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt, opcode, op, cond, N, V, Z);
    end
  end

  assign nselA     = ctrl.nsela;
  assign nselB     = ctrl.nselb;
  assign loada     = ctrl.loada;
  assign loadb     = ctrl.loadb;
  assign loadc     = ctrl.loadc;
  assign loads     = ctrl.loads;
  assign asel      = ctrl.asel;
  assign bsel      = ctrl.bsel;
  assign vsel      = ctrl.vsel;
  assign write     = ctrl.write;
  assign load_ir   = ctrl.load_ir;
  assign load_pc   = ctrl.load_pc;
  assign reset_pc  = ctrl.reset_pc;
  assign pc_sel    = ctrl.pc_sel;
  assign load_addr = ctrl.load_addr;
  assign addr_sel  = ctrl.addr_sel;
  assign mem_cmd   = ctrl.mem_cmd;
  assign halt      = ctrl.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Testbench for cpu_controller: each instruction is expanded into the list of
// per-cycle control vectors it must produce; a monitor pops and compares one
// vector per cycle.
module tb_cpu_controller;

  typedef struct packed {
    logic [2:0] nsela;
    logic [2:0] nselb;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_sel;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halt;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = '0;
  logic [1:0] op = '0;
  logic [2:0] cond = '0;
  logic       N = 1'b0, V = 1'b0, Z = 1'b0;
  logic [2:0] nselA, nselB;
  logic       loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       write, load_ir, load_pc, reset_pc, pc_sel, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       halt;

  ctrl_t act;
  ctrl_t exp_q[$];
  string nm_q[$];
  bit    mon_en = 1'b0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(N), .V(V), .Z(Z), .nselA(nselA), .nselB(nselB),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc), .pc_sel(pc_sel),
    .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halt(halt)
  );

  assign act = {nselA, nselB, loada, loadb, loadc, loads, asel, bsel, vsel, write,
                load_ir, load_pc, reset_pc, pc_sel, load_addr, addr_sel, mem_cmd, halt};

  function automatic ctrl_t rst_vec();
    ctrl_t c;
    c = '0;
    c.reset_pc = 1'b1;
    c.load_pc  = 1'b1;
    return c;
  endfunction

  task automatic check(input string nm, input ctrl_t a, input ctrl_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, a, e);
    end
  endtask

  task automatic step(input string nm, input ctrl_t c);
    exp_q.push_back(c);
    nm_q.push_back(nm);
  endtask

  // Branch outcome straight from the condition table.
  function automatic bit taken(input logic [2:0] cd, input bit n, input bit v, input bit z);
    case (cd)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one instruction starting at its IF1 cycle and queues the cycle list
  // the controller must walk through for it.
  task automatic issue(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] cd,
                       input logic n, input logic v, input logic z, input int hold);
    ctrl_t c;
    int k;
    bit t;
    @(negedge clk);
    opcode = opc; op = o; cond = cd; N = n; V = v; Z = z;
    k = exp_q.size();
    c = '0; c.addr_sel = 1; c.mem_cmd = 2'b01; step("IF1", c);
    c.load_ir = 1;                             step("IF2", c);
    c = '0; c.load_pc = 1;                     step("UPC", c);
    c = '0;                                    step("DEC", c);
    if (opc == 3'b110 && o == 2'b10) begin
      c = '0; c.nsela = 3'b001; c.vsel = 2'b10; c.write = 1; step("WIMM", c);
    end else if (opc == 3'b110 && o == 2'b00) begin
      c = '0; c.nselb = 3'b100; c.loadb = 1;                 step("GETB", c);
      c = '0; c.loadc = 1; c.asel = 1;                       step("EXEC_MOV", c);
      c = '0; c.nsela = 3'b010; c.write = 1;                 step("WB", c);
    end else if (opc == 3'b101) begin
      c = '0; c.nsela = 3'b001; c.nselb = 3'b100; c.loada = 1; c.loadb = 1;
      step("GETAB", c);
      c = '0; c.loadc = 1; c.loads = (o == 2'b01);           step("EXEC_ALU", c);
      if (o != 2'b01) begin
        c = '0; c.nsela = 3'b010; c.write = 1;               step("WB", c);
      end
    end else if ((opc == 3'b011 || opc == 3'b100) && o == 2'b00) begin
      c = '0; c.nsela = 3'b001; c.loada = 1;                 step("GETA", c);
      c = '0; c.bsel = 1; c.loadc = 1;                       step("ADDR", c);
      c = '0; c.load_addr = 1;                               step("LDA", c);
      if (opc == 3'b011) begin
        c = '0; c.mem_cmd = 2'b01;                           step("MRD1", c);
        c.nsela = 3'b010; c.vsel = 2'b11; c.write = 1;       step("MRD2", c);
      end else begin
        c = '0; c.nselb = 3'b010; c.loadb = 1;               step("GETD", c);
        c = '0; c.asel = 1; c.loadc = 1;                     step("PASS", c);
        c = '0; c.mem_cmd = 2'b10;                           step("MWR", c);
      end
    end else if (opc == 3'b001) begin
      t = taken(cd, n, v, z);
      c = '0; c.load_pc = t; c.pc_sel = t;                   step("BR", c);
    end else begin
      for (int i = 0; i < hold; i++) begin
        c = '0; c.halt = 1;                                  step("HALT", c);
      end
    end
    k = exp_q.size() - k;
    repeat (k - 1) @(negedge clk);
  endtask

  // Releases reset on a falling edge and expects one RST cycle first.
  task automatic restart();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step("RST_after_release", rst_vec());
    mon_en = 1'b1;
  endtask

  // Ends a halt episode: stop monitoring, then reset must act immediately.
  task automatic reset_from_halt(input string nm);
    #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check(nm, act, rst_vec());
  endtask

  // Monitor: one expected vector per cycle, sampled mid-low-phase.
  initial begin
    ctrl_t e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow: got %h required queued vector", act);
        end else begin
          e = exp_q.pop_front();
          n = nm_q.pop_front();
          check(n, act, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_t c;
    int r;
    repeat (3) @(negedge clk);
    #2;
    check("reset_state", act, rst_vec());
    restart();

    // Directed instructions
    issue(3'b110, 2'b10, 3'd0, 0, 0, 0, 0);  // MOV imm
    issue(3'b110, 2'b00, 3'd0, 0, 0, 0, 0);  // MOV reg
    issue(3'b101, 2'b00, 3'd0, 0, 0, 0, 0);  // ADD
    issue(3'b101, 2'b01, 3'd0, 0, 0, 0, 0);  // CMP
    issue(3'b011, 2'b00, 3'd0, 0, 0, 0, 0);  // LDR
    issue(3'b100, 2'b00, 3'd0, 0, 0, 0, 0);  // STR
    issue(3'b001, 2'b00, 3'd1, 0, 0, 1, 0);  // BEQ, Z=1
    issue(3'b001, 2'b00, 3'd1, 0, 0, 0, 0);  // BEQ, Z=0
    issue(3'b001, 2'b00, 3'd3, 1, 0, 0, 0);  // BLT, N=1 V=0
    issue(3'b001, 2'b00, 3'd5, 1, 1, 1, 0);  // never

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: issue(3'b110, 2'b10, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        1: issue(3'b110, 2'b00, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        2: issue(3'b101, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        3: issue(3'b011, 2'b00, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        4: issue(3'b100, 2'b00, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        default: issue(3'b001, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      endcase
    end

    // HALT holds for 20 cycles, then reset recovers
    issue(3'b111, 2'($urandom), 3'd0, 0, 0, 0, 20);
    reset_from_halt("reset_in_halt");
    restart();

    // Reset asserted in the middle of an ALU EXEC cycle
    @(negedge clk);
    mon_en = 1'b0;
    opcode = 3'b101; op = 2'b00;
    repeat (5) @(negedge clk);
    #2;
    c = '0; c.loadc = 1;
    check("exec_before_reset", act, c);
    reset = 1'b1;
    #1;
    check("reset_mid_exec", act, rst_vec());
    restart();
    issue(3'b101, 2'b10, 3'd0, 0, 0, 0, 0);

    // Unassigned opcode 010 also halts
    issue(3'b010, 2'b00, 3'd0, 0, 0, 0, 20);
    reset_from_halt("reset_after_illegal");
    restart();
    issue(3'b110, 2'b10, 3'd0, 0, 0, 0, 0);
    #3;
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
